// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dct_pkg
// Description : Shared constants for the DCT coefficient reordering path:
//               block size, zigzag-to-raster table and the column-major
//               buffer address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dct_pkg;

  localparam int BLK = 64;

  // Zigzag index -> raster index (row*8 + col)
  localparam logic [5:0] ZZ_RASTER [0:BLK-1] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Buffer address of zigzag index z: the DCT writes column order, so the
  // raster index r maps to (r%8)*8 + r/8, i.e. the two 3-bit halves swapped.
  function automatic logic [5:0] zz_addr(input logic [5:0] z);
    logic [5:0] r;
    r = ZZ_RASTER[z];
    return {r[2:0], r[5:3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/coef_bank_64.sv
`default_nettype none
// ============================================================================
// Module      : coef_bank_64
// Description : 64-entry coefficient buffer, one synchronous write port and
//               one asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
module coef_bank_64
  import dct_pkg::*;
#(
  parameter int BITS = 25
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [5:0]      i_waddr,
  input  logic [BITS-1:0] i_wdata,
  input  logic [5:0]      i_raddr,
  output logic [BITS-1:0] o_rdata
);

  logic [BITS-1:0] r_mem [0:BLK-1];

  // Write one coefficient per accepted input sample
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/dct_coef_zigzag_reader.sv
`default_nettype none
// ============================================================================
// Module      : dct_coef_zigzag_reader
// Description : Accepts 8x8 DCT blocks in column order into a ping-pong pair
//               of buffers and re-emits each block in JPEG zigzag order.
//               One coefficient per clock on each side, no inter-block gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_coef_zigzag_reader
  import dct_pkg::*;
#(
  parameter int bits    = 25,
  parameter int N_BANKS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [bits-1:0] O,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_first,
  output logic            out_last
);

  logic [N_BANKS-1:0] r_full;
  logic               r_wbank;
  logic               r_rbank;
  logic [5:0]         r_wcnt;
  logic [5:0]         r_rcnt;
  logic [bits-1:0]    r_o;
  logic               r_out_valid;
  logic               r_out_first;
  logic               r_out_last;

  logic               w_in_fire;
  logic               w_load;
  logic               w_wr_last;
  logic               w_rd_last;
  logic [5:0]         w_raddr;
  logic [bits-1:0]    w_rdata [N_BANKS];

  assign in_ready  = !r_full[r_wbank];
  assign w_in_fire = in_valid && in_ready;
  assign w_wr_last = (r_wcnt == 6'd63);
  // Output register refills whenever it is empty or being drained
  assign w_load    = r_full[r_rbank] && (!r_out_valid || out_ready);
  assign w_rd_last = (r_rcnt == 6'd63);
  assign w_raddr   = zz_addr(r_rcnt);

  generate
    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      coef_bank_64 #(.BITS(bits)) u_bank (
        .clk     (clk),
        .i_we    (w_in_fire && (r_wbank == 1'(b))),
        .i_waddr (r_wcnt),
        .i_wdata (in),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata[b])
      );
    end
  endgenerate

  // Write-side counter and bank pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt  <= 6'd0;
      r_wbank <= 1'b0;
    end else if (w_in_fire) begin
      r_wcnt <= r_wcnt + 6'd1;
      if (w_wr_last) begin
        r_wbank <= ~r_wbank;
      end
    end
  end

  // Bank-full flags: set by the last write, cleared by the last read.
  // Set and clear never target the same bank on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
    end else begin
      if (w_in_fire && w_wr_last) begin
        r_full[r_wbank] <= 1'b1;
      end
      if (w_load && w_rd_last) begin
        r_full[r_rbank] <= 1'b0;
      end
    end
  end

  // Read-side zigzag counter and bank pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt  <= 6'd0;
      r_rbank <= 1'b0;
    end else if (w_load) begin
      r_rcnt <= r_rcnt + 6'd1;
      if (w_rd_last) begin
        r_rbank <= ~r_rbank;
      end
    end
  end

  // Output register with block-boundary markers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o         <= '0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_o         <= w_rdata[r_rbank];
      r_out_valid <= 1'b1;
      r_out_first <= (r_rcnt == 6'd0);
      r_out_last  <= w_rd_last;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign O         = r_o;
  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_dct_coef_zigzag_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_coef_zigzag_reader
// Description : Directed self-checking bench for dct_coef_zigzag_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_coef_zigzag_reader;

  localparam int c_bits = 25;

  typedef struct {
    logic [c_bits-1:0] d;
    logic              f;
    logic              l;
    int                cyc;
  } ob_t;

  logic              clk;
  logic              rst;
  logic [c_bits-1:0] din;
  logic              in_valid;
  logic              in_ready;
  logic [c_bits-1:0] o_dat;
  logic              out_valid;
  logic              out_ready;
  logic              out_first;
  logic              out_last;

  int  n_checks;
  int  n_fail;
  int  cyc;
  int  acc_n;
  int  stall_cnt;
  int  acc63_q[$];
  ob_t out_q[$];
  bit  rnd_on;

  dct_coef_zigzag_reader #(.bits(c_bits), .N_BANKS(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .O         (o_dat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        out_q.push_back('{d: o_dat, f: out_first, l: out_last, cyc: cyc});
      end
      if (in_valid && in_ready) begin
        if (acc_n % 64 == 63) acc63_q.push_back(cyc);
        acc_n++;
      end
      if (in_valid && !in_ready) stall_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Source index (col*8+row of the column-ordered input) of zigzag entry z,
  // found by walking the anti-diagonals.
  function automatic int zz_src(input int z);
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo;
      int hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int row = lo; row <= hi; row++) begin
          if (k == z) return (s - row) * 8 + row;
          k++;
        end
      end else begin
        for (int row = hi; row >= lo; row--) begin
          if (k == z) return (s - row) * 8 + row;
          k++;
        end
      end
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    acc_n     = 0;
    stall_cnt = 0;
    out_q.delete();
    acc63_q.delete();
  endtask

  task automatic send_sample(input int d);
    bit got;
    int k;
    din      = c_bits'(d);
    in_valid = 1'b1;
    got      = 1'b0;
    k        = 0;
    while (!got && k < 400) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!got) check("in_accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic send_block(input int base, input int first_n, input int gap_pct);
    for (int n = first_n; n < 64; n++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_sample(base + n);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic check_stream(input string tag, input int bases[10], input int nblk);
    int lim;
    check($sformatf("%s_count", tag), out_q.size(), nblk * 64);
    lim = (out_q.size() < nblk * 64) ? out_q.size() : nblk * 64;
    for (int i = 0; i < lim; i++) begin
      int z;
      z = i % 64;
      check($sformatf("%s_data[%0d]", tag, i), 32'(out_q[i].d), 32'(bases[i / 64] + zz_src(z)));
      check($sformatf("%s_first[%0d]", tag, i), 32'(out_q[i].f), 32'(z == 0));
      check($sformatf("%s_last[%0d]", tag, i), 32'(out_q[i].l), 32'(z == 63));
    end
  endtask

  initial begin
    int bases[10];
    int n_rd;
    int bad;
    bit seen;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    acc_n     = 0;
    stall_cnt = 0;
    rnd_on    = 1'b0;
    din       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;

    // ---- Reset state ----
    do_reset();
    check("rst_O", 32'(o_dat), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_first", 32'(out_first), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ---- Single block in[n]=n, sink always ready ----
    out_ready = 1'b1;
    send_block(0, 0, 0);
    wait_out(64, 300);
    bases = '{default: 0};
    check_stream("t1", bases, 1);
    if (out_q.size() > 0 && acc63_q.size() > 0)
      check("t1_latency", 32'(out_q[0].cyc - acc63_q[0]), 32'd2);
    else
      check("t1_latency_missing", 32'(out_q.size()), 32'd64);

    // ---- Three back-to-back blocks, sink always ready ----
    do_reset();
    out_ready = 1'b1;
    send_block(0, 0, 0);
    send_block(100, 0, 0);
    send_block(200, 0, 0);
    wait_out(192, 400);
    check("t2_in_stalls", 32'(stall_cnt), 32'd0);
    bases = '{0, 100, 200, 0, 0, 0, 0, 0, 0, 0};
    check_stream("t2", bases, 3);
    if (out_q.size() >= 192 && acc63_q.size() >= 2) begin
      bad = 0;
      for (int i = 1; i < 192; i++) if (out_q[i].cyc != out_q[i-1].cyc + 1) bad++;
      check("t2_bubbles", 32'(bad), 32'd0);
      check("t2_blk2_dc", 32'(out_q[64].d), 32'd100);
      check("t2_blk3_dc", 32'(out_q[128].d), 32'd200);
      // B's sample 63 is written on the same edge that loads A's index 63
      check("t2_coincide_last", 32'(out_q[63].cyc), 32'(acc63_q[1] + 1));
      check("t2_coincide_dc", 32'(out_q[64].cyc), 32'(out_q[63].cyc + 1));
    end else begin
      check("t2_short", 32'(out_q.size()), 32'd192);
    end

    // ---- Sink stalled while three blocks are offered ----
    do_reset();
    out_ready = 1'b0;
    send_block(0, 0, 0);
    send_block(100, 0, 0);
    check("t3_acc128", 32'(acc_n), 32'd128);
    check("t3_no_stall_before_full", 32'(stall_cnt), 32'd0);
    din      = c_bits'(200);
    in_valid = 1'b1;
    @(negedge clk);
    check("t3_in_ready_low", 32'(in_ready), 32'd0);
    check("t3_out_valid", 32'(out_valid), 32'd1);
    check("t3_O_dc", 32'(o_dat), 32'd0);
    check("t3_first", 32'(out_first), 32'd1);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_dat !== '0 || out_valid !== 1'b1 || out_first !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("t3_hold_stable", 32'(bad), 32'd0);
    check("t3_no_accept_while_full", 32'(acc_n), 32'd128);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n_rd = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
      else if (out_valid && out_ready) n_rd++;
    end
    check("t3_ready_returns", 32'(seen), 32'd1);
    check("t3_reads_before_ready", 32'(n_rd), 32'd63);
    check("t3_O_at_free", 32'(o_dat), 32'd63);
    check("t3_last_at_free", 32'(out_last), 32'd1);
    @(posedge clk);
    #1;
    send_block(200, 1, 0);
    wait_out(192, 400);
    bases = '{0, 100, 200, 0, 0, 0, 0, 0, 0, 0};
    check_stream("t3", bases, 3);

    // ---- Random sink ready and source gaps over 10 blocks ----
    do_reset();
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int b = 0; b < 10; b++) begin
      bases[b] = 1000 * (b + 1);
      send_block(bases[b], 0, 30);
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_out(640, 1500);
    check_stream("t4", bases, 10);

    // ---- Reset discards a buffered and a partial block ----
    do_reset();
    out_ready = 1'b0;
    send_block(0, 0, 0);
    for (int n = 0; n < 30; n++) send_sample(300 + n);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_out_valid_after_rst", 32'(out_valid), 32'd0);
    check("t5_in_ready_after_rst", 32'(in_ready), 32'd1);
    out_q.delete();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_stale_output", 32'(out_q.size()), 32'd0);
    send_block(500, 0, 0);
    wait_out(64, 300);
    repeat (10) @(posedge clk);
    #1;
    if (out_q.size() > 0) begin
      check("t5_first_value", 32'(out_q[0].d), 32'd500);
      check("t5_first_flag", 32'(out_q[0].f), 32'd1);
    end
    bases = '{default: 500};
    check_stream("t5", bases, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
